stream_interface_tag: RTL and testbench
=======================================

# stream_interface_tag

Tag-managed bridge between the multi-stream buffer's per-stream fetch requests and the OpenCAPI 3.0 memory interface. It accepts a stream request (stream id, effective address) and allocates a free transaction tag. It issues the memory request with that tag and records the stream id and L2 line pointer per tag. When the tagged response returns, it re-associates the data with its stream and pointer and delivers it to the buffer's fill path.

## Interface
Parameters:
- addr_width, 64, effective-address width
- data_width, 1024, response data width (one cache line)
- nstrms, 64, number of streams; nstrms_width = $clog2(nstrms)
- tag, 256, number of transaction tags; tag_width = $clog2(tag)
- l2_ncl, 256, L2 cache lines; l2_ncl_width = $clog2(l2_ncl)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req_v  in  1  stream request valid
- i_req_r  out  1  stream request ready
- i_req_sid  in  nstrms_width  requesting stream id
- i_req_ea  in  addr_width  requested line address
- o_rsp_v  out  1  stream response valid
- o_rsp_r  in  1  stream response ready
- o_rsp_data  out  data_width  line data
- o_rsp_sid  out  nstrms_width  stream id of the line
- o_rsp_ptr  out  l2_ncl_width  L2 line pointer of the line
- o_req_v  out  1  memory request valid
- o_req_r  in  1  memory request ready
- o_req_ea  out  addr_width  memory request address
- o_req_tag  out  tag_width  memory request tag
- i_rsp_v  in  1  memory response valid
- i_rsp_r  out  1  memory response ready
- i_rsp_tag  in  tag_width  memory response tag
- i_rsp_data  in  data_width  memory response data, sampled with i_rsp_v

## Operation
- A handshake completes on any cycle where v and r are both high.
- Free list: a 256-entry tag FIFO. After reset it holds tags 0,1,…,255 in order (initialised by reset, or by a post-reset fill that keeps i_req_r low until complete). Allocation pops the head. Release pushes the tag at the tail.
- Tag table: a tag-indexed array of {sid, ptr}. It is written on the i_req handshake with ptr = i_req_ea[l2_ncl_width-1:0]. It is read combinationally on i_rsp_tag.
- Request path:
  - i_req_r = free list non-empty && (!o_req_v || o_req_r).
  - On handshake, register o_req_ea = i_req_ea and o_req_tag = head tag, set o_req_v and pop the free list.
  - o_req_v and its payload hold stable until the o_req handshake.
- Response path:
  - i_rsp_r = !o_rsp_v || o_rsp_r.
  - On handshake, register o_rsp_data = i_rsp_data and o_rsp_sid/o_rsp_ptr = table[i_rsp_tag], set o_rsp_v and push i_rsp_tag onto the free list.
  - The output holds until the o_rsp handshake.
- Simultaneous allocate and release in one cycle: both take effect; the count is unchanged.
- Empty free list: i_req_r = 0. A tag released in that cycle is not bypassed; it becomes allocatable the next cycle.
- Full free list: release cannot occur, because only issued tags return. Responses with a non-outstanding tag are illegal and not checked.
- Responses may return out of order. Each is routed purely by tag.

## Timing
- Reset values: o_req_v=0, o_rsp_v=0, o_req_ea=0, o_req_tag=0, o_rsp_data=0, o_rsp_sid=0, o_rsp_ptr=0, free list = 0..255, i_rsp_r=1.
- i_req_r is high in the first cycle after reset deassertion unless the fill option is used.
- Request latency: handshake at edge N gives o_req_v high after edge N. Throughput is 1 request per cycle while tags remain and o_req_r is high.
- Response latency: handshake at edge M gives o_rsp_v high after edge M. Throughput is 1 response per cycle.
- The table entry written at edge N is readable from cycle N+1, so a response to a tag is legal one cycle after o_req_v rises.
- Asserting reset mid-operation clears all valids and restores the full free list immediately. Outstanding tags are forgotten.

## Test plan
- Basic: after reset, i_req sid=1 ea=2, with memory looped back by a one-stage register and o_rsp_r=1 → o_req_tag=0, o_req_ea=2, then o_rsp_v with o_rsp_sid=1 and o_rsp_ptr=2; data matches i_rsp_data.
- Second request: sid=1 ea=4 issued 3 cycles later → o_req_tag=1, o_rsp_ptr=4, o_rsp_sid=1.
- Exhaustion: 256 requests with no responses → tags 0..255 in order, then i_req_r=0. Return tag 7 → i_req_r=1 next cycle and the next allocation is tag 7.
- Out-of-order: issue tags 0 (sid 3, ea 0x10) and 1 (sid 5, ea 0x21), respond tag 1 first → o_rsp sid 5 ptr 0x21, then sid 3 ptr 0x10.
- Backpressure: hold o_req_r=0 → o_req payload stable and i_req_r=0. Hold o_rsp_r=0 → o_rsp stable and i_rsp_r=0. Releasing either completes with no loss or duplication.
- Reset mid-flight with 3 tags outstanding → all valids 0, and the next allocation is tag 0.

Source files
------------

// File: rtl/stream_interface_tag.sv
// Generic FIFO; optional reset fill with 0..depth-1 so it can serve as a free list.
// Latency: pop_dat shows the head combinationally; a push is visible one cycle later.
// Backpressure: none internally; callers must not push when full or pop when empty.
module fifo #(
    parameter int width    = 8,
    parameter int depth    = 256,
    parameter bit init_seq = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [width-1:0] push_dat,
    input  logic             pop_vld,
    output logic [width-1:0] pop_dat,
    output logic             empty
);
    localparam int aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int cw = aw + 1;
    localparam logic [aw-1:0] last     = aw'(depth - 1);
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic             pop_en;

    assign empty   = (cnt_q == '0);
    assign pop_en  = pop_vld && !empty;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = (wr_ptr_q == last) ? '0 : wr_ptr_q + aw'(1);
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == last) ? '0 : rd_ptr_q + aw'(1);
        end
        unique case ({push_vld, pop_en})
            2'b10:   cnt_d = cnt_q + cw'(1);
            2'b01:   cnt_d = cnt_q - cw'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // A full initial fill leaves the write pointer wrapped back to entry 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= init_seq ? width'(i) : '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= init_seq ? full_cnt : '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// Tag bridge: allocates a free tag per stream fetch, restores {sid, ptr} by tag on return.
// Latency: one cycle from i_req handshake to o_req_v, one cycle from i_rsp handshake to o_rsp_v.
// Backpressure: i_req_r drops when tags run out or o_req stalls; i_rsp_r drops while o_rsp stalls.
module stream_interface_tag #(
    parameter int addr_width   = 64,
    parameter int data_width   = 1024,
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int tag          = 256,
    parameter int tag_width    = $clog2(tag),
    parameter int l2_ncl       = 256,
    parameter int l2_ncl_width = $clog2(l2_ncl)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [nstrms_width-1:0] i_req_sid,
    input  logic [addr_width-1:0]   i_req_ea,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [data_width-1:0]   o_rsp_data,
    output logic [nstrms_width-1:0] o_rsp_sid,
    output logic [l2_ncl_width-1:0] o_rsp_ptr,
    output logic                    o_req_v,
    input  logic                    o_req_r,
    output logic [addr_width-1:0]   o_req_ea,
    output logic [tag_width-1:0]    o_req_tag,
    input  logic                    i_rsp_v,
    output logic                    i_rsp_r,
    input  logic [tag_width-1:0]    i_rsp_tag,
    input  logic [data_width-1:0]   i_rsp_data
);
    typedef struct packed {
        logic [nstrms_width-1:0] sid;
        logic [l2_ncl_width-1:0] ptr;
    } tag_ent_t;

    tag_ent_t table_q [tag];
    tag_ent_t table_d [tag];
    tag_ent_t rsp_ent;

    logic                    o_req_v_q, o_req_v_d;
    logic [addr_width-1:0]   o_req_ea_q, o_req_ea_d;
    logic [tag_width-1:0]    o_req_tag_q, o_req_tag_d;
    logic                    o_rsp_v_q, o_rsp_v_d;
    logic [data_width-1:0]   o_rsp_data_q, o_rsp_data_d;
    logic [nstrms_width-1:0] o_rsp_sid_q, o_rsp_sid_d;
    logic [l2_ncl_width-1:0] o_rsp_ptr_q, o_rsp_ptr_d;

    logic                    free_empty;
    logic [tag_width-1:0]    free_head;
    logic                    req_hs;
    logic                    rsp_hs;

    // No bypass: a tag released this cycle only clears free_empty next cycle.
    assign i_req_r = !free_empty && (!o_req_v_q || o_req_r);
    assign i_rsp_r = !o_rsp_v_q || o_rsp_r;
    assign req_hs  = i_req_v && i_req_r;
    assign rsp_hs  = i_rsp_v && i_rsp_r;
    assign rsp_ent = table_q[i_rsp_tag];

    fifo #(
        .width    (tag_width),
        .depth    (tag),
        .init_seq (1'b1)
    ) u_free_list (
        .clk      (clk),
        .reset    (reset),
        .push_vld (rsp_hs),
        .push_dat (i_rsp_tag),
        .pop_vld  (req_hs),
        .pop_dat  (free_head),
        .empty    (free_empty)
    );

    always_comb begin
        table_d = table_q;
        if (req_hs) begin
            table_d[free_head] = '{sid: i_req_sid, ptr: i_req_ea[l2_ncl_width-1:0]};
        end
    end

    always_comb begin
        o_req_v_d   = o_req_v_q;
        o_req_ea_d  = o_req_ea_q;
        o_req_tag_d = o_req_tag_q;
        if (req_hs) begin
            o_req_v_d   = 1'b1;
            o_req_ea_d  = i_req_ea;
            o_req_tag_d = free_head;
        end else if (o_req_r) begin
            o_req_v_d = 1'b0;
        end
    end

    always_comb begin
        o_rsp_v_d    = o_rsp_v_q;
        o_rsp_data_d = o_rsp_data_q;
        o_rsp_sid_d  = o_rsp_sid_q;
        o_rsp_ptr_d  = o_rsp_ptr_q;
        if (rsp_hs) begin
            o_rsp_v_d    = 1'b1;
            o_rsp_data_d = i_rsp_data;
            o_rsp_sid_d  = rsp_ent.sid;
            o_rsp_ptr_d  = rsp_ent.ptr;
        end else if (o_rsp_r) begin
            o_rsp_v_d = 1'b0;
        end
    end

    // Table entries are only meaningful once their tag is allocated, so no reset.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_req_v_q    <= 1'b0;
            o_req_ea_q   <= '0;
            o_req_tag_q  <= '0;
            o_rsp_v_q    <= 1'b0;
            o_rsp_data_q <= '0;
            o_rsp_sid_q  <= '0;
            o_rsp_ptr_q  <= '0;
        end else begin
            o_req_v_q    <= o_req_v_d;
            o_req_ea_q   <= o_req_ea_d;
            o_req_tag_q  <= o_req_tag_d;
            o_rsp_v_q    <= o_rsp_v_d;
            o_rsp_data_q <= o_rsp_data_d;
            o_rsp_sid_q  <= o_rsp_sid_d;
            o_rsp_ptr_q  <= o_rsp_ptr_d;
        end
    end

    assign o_req_v    = o_req_v_q;
    assign o_req_ea   = o_req_ea_q;
    assign o_req_tag  = o_req_tag_q;
    assign o_rsp_v    = o_rsp_v_q;
    assign o_rsp_data = o_rsp_data_q;
    assign o_rsp_sid  = o_rsp_sid_q;
    assign o_rsp_ptr  = o_rsp_ptr_q;
endmodule

// File: tb/tb_stream_interface_tag.sv
// Randomized bench for stream_interface_tag against a queue-based free-list/tag-map model.
module tb_stream_interface_tag;
    localparam int AW = 64;
    localparam int DW = 1024;
    localparam int SW = 6;
    localparam int TW = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req_v, i_req_r;
    logic [SW-1:0] i_req_sid;
    logic [AW-1:0] i_req_ea;
    logic          o_rsp_v, o_rsp_r;
    logic [DW-1:0] o_rsp_data;
    logic [SW-1:0] o_rsp_sid;
    logic [PW-1:0] o_rsp_ptr;
    logic          o_req_v, o_req_r;
    logic [AW-1:0] o_req_ea;
    logic [TW-1:0] o_req_tag;
    logic          i_rsp_v, i_rsp_r;
    logic [TW-1:0] i_rsp_tag;
    logic [DW-1:0] i_rsp_data;

    always #5 clk = ~clk;

    stream_interface_tag dut (
        .clk        (clk),
        .reset      (reset),
        .i_req_v    (i_req_v),
        .i_req_r    (i_req_r),
        .i_req_sid  (i_req_sid),
        .i_req_ea   (i_req_ea),
        .o_rsp_v    (o_rsp_v),
        .o_rsp_r    (o_rsp_r),
        .o_rsp_data (o_rsp_data),
        .o_rsp_sid  (o_rsp_sid),
        .o_rsp_ptr  (o_rsp_ptr),
        .o_req_v    (o_req_v),
        .o_req_r    (o_req_r),
        .o_req_ea   (o_req_ea),
        .o_req_tag  (o_req_tag),
        .i_rsp_v    (i_rsp_v),
        .i_rsp_r    (i_rsp_r),
        .i_rsp_tag  (i_rsp_tag),
        .i_rsp_data (i_rsp_data)
    );

    typedef struct {
        int            tag;
        logic [AW-1:0] ea;
    } oreq_t;
    typedef struct {
        logic [DW-1:0] data;
        int            sid;
        int            ptr;
    } orsp_t;

    // Reference state: free tags in allocation order, per-tag owner, and pending outputs.
    int    free_tags[$];
    int    outst[$];
    oreq_t req_q[$];
    orsp_t rsp_q[$];
    int    map_sid[256];
    int    map_ptr[256];
    int    log_sid[$];

    int n_tests = 0;
    int n_fail  = 0;

    int            p_req, p_oreq_r, p_rsp, p_orsp_r;
    bit            use_fix;
    int            fix_sid;
    logic [AW-1:0] fix_ea;
    int            want_tag;
    int            rsp_idx;
    int            last_issued;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        free_tags.delete();
        for (int i = 0; i < 256; i++) free_tags.push_back(i);
        outst.delete();
        req_q.delete();
        rsp_q.delete();
    endtask

    task automatic do_reset();
        #2;
        reset   = 1'b0;
        i_req_v = 1'b0;
        i_rsp_v = 1'b0;
        o_req_r = 1'b0;
        o_rsp_r = 1'b0;
        model_reset();
        #1;
        check("rst_o_req_v", DW'(o_req_v), DW'(0));
        check("rst_o_rsp_v", DW'(o_rsp_v), DW'(0));
        check("rst_o_req_ea", DW'(o_req_ea), DW'(0));
        check("rst_o_req_tag", DW'(o_req_tag), DW'(0));
        check("rst_o_rsp_data", o_rsp_data, DW'(0));
        check("rst_o_rsp_sid", DW'(o_rsp_sid), DW'(0));
        check("rst_o_rsp_ptr", DW'(o_rsp_ptr), DW'(0));
        check("rst_i_rsp_r", DW'(i_rsp_r), DW'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step();
        bit exp_ireq_r, exp_irsp_r;
        int t;
        @(posedge clk);
        #1;
        i_req_v = ($urandom_range(99) < p_req);
        if (use_fix) begin
            i_req_sid = SW'(fix_sid);
            i_req_ea  = fix_ea;
        end else begin
            i_req_sid = SW'($urandom_range(63));
            i_req_ea  = {32'($urandom()), 32'($urandom())};
        end
        o_req_r = ($urandom_range(99) < p_oreq_r);
        o_rsp_r = ($urandom_range(99) < p_orsp_r);
        i_rsp_v = 1'b0;
        rsp_idx = -1;
        if (outst.size() > 0 && $urandom_range(99) < p_rsp) begin
            if (want_tag >= 0) begin
                foreach (outst[k]) if (outst[k] == want_tag) rsp_idx = k;
            end else begin
                rsp_idx = int'($urandom_range(outst.size() - 1));
            end
        end
        if (rsp_idx >= 0) begin
            i_rsp_v   = 1'b1;
            i_rsp_tag = TW'(outst[rsp_idx]);
            for (int w = 0; w < DW / 32; w++) i_rsp_data[w*32 +: 32] = $urandom();
        end
        @(negedge clk);

        exp_ireq_r = (free_tags.size() > 0) && (req_q.size() == 0 || o_req_r);
        exp_irsp_r = (rsp_q.size() == 0) || o_rsp_r;
        check("i_req_r", DW'(i_req_r), DW'(exp_ireq_r));
        check("i_rsp_r", DW'(i_rsp_r), DW'(exp_irsp_r));
        check("o_req_v", DW'(o_req_v), DW'(req_q.size() != 0));
        if (req_q.size() != 0) begin
            check("o_req_tag", DW'(o_req_tag), DW'(req_q[0].tag));
            check("o_req_ea", DW'(o_req_ea), DW'(req_q[0].ea));
        end
        check("o_rsp_v", DW'(o_rsp_v), DW'(rsp_q.size() != 0));
        if (rsp_q.size() != 0) begin
            check("o_rsp_data", o_rsp_data, rsp_q[0].data);
            check("o_rsp_sid", DW'(o_rsp_sid), DW'(rsp_q[0].sid));
            check("o_rsp_ptr", DW'(o_rsp_ptr), DW'(rsp_q[0].ptr));
        end

        if (o_req_v && o_req_r) last_issued = int'(o_req_tag);
        if (o_rsp_v && o_rsp_r) log_sid.push_back(int'(o_rsp_sid));

        if (req_q.size() != 0 && o_req_r) begin
            outst.push_back(req_q[0].tag);
            void'(req_q.pop_front());
        end
        if (rsp_q.size() != 0 && o_rsp_r) void'(rsp_q.pop_front());
        if (i_req_v && exp_ireq_r) begin
            t = free_tags.pop_front();
            map_sid[t] = int'(i_req_sid);
            map_ptr[t] = int'(i_req_ea % 256);
            req_q.push_back('{tag: t, ea: i_req_ea});
        end
        if (i_rsp_v && exp_irsp_r) begin
            t = int'(i_rsp_tag);
            rsp_q.push_back('{data: i_rsp_data, sid: map_sid[t], ptr: map_ptr[t]});
            free_tags.push_back(t);
            outst.delete(rsp_idx);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int sid, input logic [AW-1:0] ea);
        use_fix = 1'b1;
        fix_sid = sid;
        fix_ea  = ea;
        p_req   = 100;
        step();
        p_req   = 0;
        use_fix = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        i_req_v = 1'b0; i_req_sid = '0; i_req_ea = '0;
        o_req_r = 1'b0; o_rsp_r = 1'b0;
        i_rsp_v = 1'b0; i_rsp_tag = '0; i_rsp_data = '0;
        use_fix = 1'b0; fix_sid = 0; fix_ea = '0;
        want_tag = -1; rsp_idx = -1; last_issued = -1;
        p_req = 0; p_oreq_r = 100; p_rsp = 100; p_orsp_r = 100;
        do_reset();

        // Basic request, then a second one a few cycles later.
        send(1, 64'h2);
        run(5);
        check("basic_tag", DW'(last_issued), DW'(0));
        send(1, 64'h4);
        run(5);
        check("second_tag", DW'(last_issued), DW'(1));

        // Out-of-order return.
        do_reset();
        p_rsp = 0;
        send(3, 64'h10);
        send(5, 64'h21);
        run(3);
        log_sid.delete();
        p_rsp = 100; want_tag = 1;
        run(3);
        want_tag = 0;
        run(3);
        want_tag = -1;
        check("ooo_count", DW'(log_sid.size()), DW'(2));
        if (log_sid.size() == 2) begin
            check("ooo_first_sid", DW'(log_sid[0]), DW'(5));
            check("ooo_second_sid", DW'(log_sid[1]), DW'(3));
        end

        // Exhaustion, then release one tag.
        do_reset();
        p_rsp = 0; p_req = 100;
        run(270);
        check("exhaust_ready", DW'(i_req_r), DW'(0));
        check("exhaust_last", DW'(last_issued), DW'(255));
        p_req = 0; p_rsp = 100; want_tag = 7;
        run(1);
        p_rsp = 0; want_tag = -1; p_req = 100;
        run(4);
        check("realloc_tag", DW'(last_issued), DW'(7));

        // Backpressure on both output sides.
        do_reset();
        p_req = 100; p_oreq_r = 0; p_rsp = 0;
        run(10);
        p_oreq_r = 100;
        run(8);
        p_req = 0; p_orsp_r = 0; p_rsp = 100;
        run(12);
        p_orsp_r = 100;
        run(20);

        // Reset with three tags outstanding.
        p_req = 100; p_rsp = 0;
        run(3);
        do_reset();
        check("midrst_o_req_v", DW'(o_req_v), DW'(0));
        check("midrst_o_rsp_v", DW'(o_rsp_v), DW'(0));
        p_req = 0;
        send(2, 64'h33);
        run(3);
        check("midrst_tag", DW'(last_issued), DW'(0));

        // Random traffic with varying pressure.
        for (int ph = 0; ph < 10; ph++) begin
            p_req    = int'($urandom_range(20, 100));
            p_oreq_r = int'($urandom_range(10, 100));
            p_rsp    = int'($urandom_range(10, 100));
            p_orsp_r = int'($urandom_range(10, 100));
            run(300);
        end
        p_req = 0; p_oreq_r = 100; p_rsp = 100; p_orsp_r = 100;
        run(600);
        check("drain_o_req_v", DW'(o_req_v), DW'(0));
        check("drain_o_rsp_v", DW'(o_rsp_v), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
